// File: rtl/bcd_display_driver.sv
// Purpose : 16-bit binary to 5-digit BCD (shift-and-add-3) with five active-low 7-segment drivers.
// Latency : result and HEX valid 16 cycles after load is sampled; one conversion per 18 cycles.
// Backpr. : none; load is accepted only in IDLE, and any load seen while busy is dropped.
//
// Ports:
//   Clock, Resetn     - system clock, asynchronous active-low reset
//   load, data_in     - start request and the 16-bit unsigned value it captures
//   busy, done        - busy while not IDLE; done is a one-cycle pulse when bcd updates
//   bcd               - held 5-digit BCD result, [19:16] = ten-thousands .. [3:0] = units
//   HEX4..HEX0        - active-low {g,f,e,d,c,b,a} segments of the held result; HEX0 = units
module bcd_display_driver #(
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        load,
   input  logic [15:0] data_in,
   output logic        busy,
   output logic        done,
   output logic [19:0] bcd,
   output logic [6:0]  HEX4,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX0
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] shift_q;
   logic [19:0] scratch_q;
   logic [3:0]  cnt_q;
   logic [19:0] bcd_q;

   logic [19:0] adj;
   logic [19:0] scratch_step;
   logic [4:1]  blank;

   // One double-dabble step: correct every digit >= 5 by +3 so the
   // following doubling carries into the next digit, then shift in the next bit.
   always_comb begin
      adj = scratch_q;
      for (int i = 0; i < 5; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         end
      end
      scratch_step = {adj[18:0], shift_q[15]};
   end

   // State register
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (load) state_d = SHIFT;
         SHIFT:   if (cnt_q == 4'd15) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
   end

   // Conversion datapath
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         bcd_q     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (load) begin
                  shift_q   <= data_in;
                  scratch_q <= '0;
                  cnt_q     <= '0;
               end
            end
            SHIFT: begin
               scratch_q <= scratch_step;
               shift_q   <= {shift_q[14:0], 1'b0};
               cnt_q     <= cnt_q + 4'd1;
               // Publish only on the last step so the display never shows a partial value.
               if (cnt_q == 4'd15) begin
                  bcd_q <= scratch_step;
               end
            end
            default: ;
         endcase
      end
   end

   assign bcd = bcd_q;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      unique case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // A digit is blanked only if it and every digit above it are zero,
   // so internal zeros (e.g. 1000) stay visible.
   always_comb begin
      blank[4] = BLANK_LEADING && (bcd_q[19:16] == 4'd0);
      blank[3] = blank[4] && (bcd_q[15:12] == 4'd0);
      blank[2] = blank[3] && (bcd_q[11:8]  == 4'd0);
      blank[1] = blank[2] && (bcd_q[7:4]   == 4'd0);
   end

   assign HEX4 = blank[4] ? 7'b1111111 : seg7(bcd_q[19:16]);
   assign HEX3 = blank[3] ? 7'b1111111 : seg7(bcd_q[15:12]);
   assign HEX2 = blank[2] ? 7'b1111111 : seg7(bcd_q[11:8]);
   assign HEX1 = blank[1] ? 7'b1111111 : seg7(bcd_q[7:4]);
   assign HEX0 = seg7(bcd_q[3:0]);

endmodule

// File: tb/tb_bcd_display_driver.sv
// Purpose : directed bench for bcd_display_driver, blanking (u0) and non-blanking (u1) builds.
// Latency : expects done/bcd exactly 16 edges after load is sampled, IDLE again after edge 17.
// Backpr. : loads issued while busy must be ignored.
module tb_bcd_display_driver;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
   localparam logic [6:0] S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
   localparam logic [6:0] S3 = 7'b0110000, SB = 7'b1111111;

   logic        Clock, Resetn;
   logic        load, load1;
   logic [15:0] data_in, data_in1;
   logic        busy, done, busy1, done1;
   logic [19:0] bcd, bcd1;
   logic [6:0]  HEX4, HEX3, HEX2, HEX1, HEX0;
   logic [6:0]  H4b, H3b, H2b, H1b, H0b;

   int checks = 0;
   int errors = 0;

   bcd_display_driver #(.BLANK_LEADING(1'b1)) u0 (
      .Clock(Clock), .Resetn(Resetn), .load(load), .data_in(data_in),
      .busy(busy), .done(done), .bcd(bcd),
      .HEX4(HEX4), .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0)
   );

   bcd_display_driver #(.BLANK_LEADING(1'b0)) u1 (
      .Clock(Clock), .Resetn(Resetn), .load(load1), .data_in(data_in1),
      .busy(busy1), .done(done1), .bcd(bcd1),
      .HEX4(H4b), .HEX3(H3b), .HEX2(H2b), .HEX1(H1b), .HEX0(H0b)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk_hex(input string tag, input logic [6:0] h4, h3, h2, h1, h0);
      chk({tag, "_hex4"}, {25'd0, HEX4}, {25'd0, h4});
      chk({tag, "_hex3"}, {25'd0, HEX3}, {25'd0, h3});
      chk({tag, "_hex2"}, {25'd0, HEX2}, {25'd0, h2});
      chk({tag, "_hex1"}, {25'd0, HEX1}, {25'd0, h1});
      chk({tag, "_hex0"}, {25'd0, HEX0}, {25'd0, h0});
   endtask

   // Full conversion on u0 with per-edge busy/done timing checks; returns 1ns after E17.
   task automatic run(input string tag, input logic [15:0] d, input logic [19:0] exp);
      load = 1'b1; data_in = d;
      tick();                                 // E0
      load = 1'b0; load1 = 1'b0;
      chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
      chk({tag, "_done_e0"}, {31'd0, done}, 32'd0);
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk({tag, "_done_step"}, {31'd0, done}, {31'd0, (k == 16)});
         chk({tag, "_busy_step"}, {31'd0, busy}, 32'd1);
      end
      chk({tag, "_bcd"}, {12'd0, bcd}, {12'd0, exp});
      tick();                                 // E17
      chk({tag, "_busy_e17"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done_e17"}, {31'd0, done}, 32'd0);
      chk({tag, "_bcd_hold"}, {12'd0, bcd}, {12'd0, exp});
   endtask

   initial begin
      Resetn = 1'b0; load = 1'b0; load1 = 1'b0; data_in = '0; data_in1 = '0;
      #3;
      // Reset state, before any clock edge
      chk("rst_bcd", {12'd0, bcd}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk_hex("rst", SB, SB, SB, SB, S0);
      chk("rst_u1_hex4", {25'd0, H4b}, {25'd0, S0});
      chk("rst_u1_hex1", {25'd0, H1b}, {25'd0, S0});
      tick();
      Resetn = 1'b1;
      tick();

      // Basic conversion
      run("c255", 16'd255, 20'h00255);
      chk_hex("c255", SB, SB, S2, S5, S5);

      // Maximum input
      run("cffff", 16'hFFFF, 20'h65535);
      chk_hex("cffff", S6, S5, S5, S3, S5);

      // Zero on u0, 7 on the non-blanking u1 in parallel
      load1 = 1'b1; data_in1 = 16'd7;
      run("c0", 16'd0, 20'h00000);
      chk_hex("c0", SB, SB, SB, SB, S0);
      chk("u1_bcd", {12'd0, bcd1}, 32'h7);
      chk("u1_hex4", {25'd0, H4b}, {25'd0, S0});
      chk("u1_hex3", {25'd0, H3b}, {25'd0, S0});
      chk("u1_hex2", {25'd0, H2b}, {25'd0, S0});
      chk("u1_hex1", {25'd0, H1b}, {25'd0, S0});
      chk("u1_hex0", {25'd0, H0b}, {25'd0, S7});

      // Loads while busy are dropped
      load = 1'b1; data_in = 16'd300;
      tick();                                 // E0
      load = 1'b0;
      repeat (4) tick();                      // E1..E4
      load = 1'b1; data_in = 16'd1;
      tick();                                 // E5
      load = 1'b0;
      chk("ign_hex_stable", {25'd0, HEX0}, {25'd0, S0});
      repeat (10) tick();                     // E6..E15
      chk("ign_done_e15", {31'd0, done}, 32'd0);
      load = 1'b1; data_in = 16'd1;
      tick();                                 // E16
      load = 1'b0;
      chk("ign_done_e16", {31'd0, done}, 32'd1);
      chk("ign_bcd", {12'd0, bcd}, 32'h00300);
      tick();                                 // E17
      chk("ign_busy_e17", {31'd0, busy}, 32'd0);
      tick();                                 // E18
      chk("ign_busy_e18", {31'd0, busy}, 32'd0);
      chk("ign_bcd_e18", {12'd0, bcd}, 32'h00300);

      // Internal zeros are not blanked
      run("c1000", 16'd1000, 20'h01000);
      chk_hex("c1000", SB, S1, S0, S0, S0);

      // Asynchronous reset mid-conversion
      load = 1'b1; data_in = 16'd9999;
      tick();                                 // E0
      load = 1'b0;
      repeat (8) tick();                      // E1..E8
      chk("mid_busy", {31'd0, busy}, 32'd1);
      #2 Resetn = 1'b0;
      #1;
      chk("mid_rst_bcd", {12'd0, bcd}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk_hex("mid_rst", SB, SB, SB, SB, S0);
      tick();
      Resetn = 1'b1;
      tick();
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      run("c42", 16'd42, 20'h00042);
      chk_hex("c42", SB, SB, SB, 7'b0011001, S2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcd_display_driver.md
# bcd_display_driver

Sequential binary-to-BCD converter and 7-segment driver that sits directly downstream of the operand/sum datapath mux and consumes its registered 16-bit `data_out`. On each `load` pulse it captures a 16-bit unsigned value and runs a 16-step shift-and-add-3 (double-dabble) conversion. It holds the resulting 5-digit BCD value and drives five active-low 7-segment displays from that held value. The display remains stable while a new conversion is in progress.

## Interface
- `BLANK_LEADING`, default 1: when 1, leading-zero digits on HEX4..HEX1 are blanked; when 0, all five digits are always shown.
- One clock; reset is asynchronous and active-low.
- `Clock`  in  1  system clock; all state updates on the rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `load`  in  1  start request; sampled only in IDLE.
- `data_in`  in  16  unsigned value to convert, sampled with `load`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse, high for the single cycle in state DONE.
- `bcd`  out  20  registered result, digits [19:16]..[3:0] = ten-thousands..units.
- `HEX4`..`HEX0`  out  7 each  active-low segments {g,f,e,d,c,b,a}; HEX0 is the units digit.

## Operation
- State machine states:
  - IDLE: if `load`=1, capture `data_in` into a 16-bit shift register, clear the 20-bit scratch, clear the 4-bit step count, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: one step per cycle.
    - Each scratch digit ≥5 gets +3 (mod 16, per nibble).
    - Then {scratch, shift} shifts left by 1; the shift-register MSB enters scratch bit 0.
    - Increment the count. On the step where count=15, write the post-step scratch into `bcd` and go to DONE.
  - DONE: `done`=1; unconditionally go to IDLE on the next edge.
- `load` in SHIFT or DONE is ignored; it is neither queued nor used to restart a conversion.
- `bcd` changes only on the DONE-entry edge and on reset.
- Max input 65535 gives 20'h65535, so the top digit never exceeds 6. No overflow is possible.
- Segment encoding, {g..a}, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- HEX outputs are combinational decodes of the registered `bcd` only, never of the scratch.
- Blanking (BLANK_LEADING=1): digit k (k=4..1) is blank iff it and every higher digit are 0. HEX0 is never blanked.
- Reset (async, any state, including mid-conversion):
  - state=IDLE, count=0, scratch=0, shift register=0
  - `bcd`=0, `busy`=0, `done`=0
  - any partial conversion is discarded

## Timing
- Let E0 be the rising edge that samples `load`=1 in IDLE.
- After E0: `busy`=1.
- Edges E1..E16 perform the 16 shift steps. E16 updates `bcd` and enters DONE.
- `done`=1 and the new `bcd`/HEX values are valid from E16 to E17.
- E17 returns to IDLE, so `busy` falls after E17. The earliest next accepted `load` is at E18.
- Latency: 16 cycles from load-sample to result. Throughput: one conversion per 18 cycles.
- Reset values:
  - `bcd`=20'h00000, HEX0=1000000
  - HEX4..HEX1=1111111 if BLANK_LEADING=1, else 1000000
  - `busy`=0, `done`=0
- `load` held high continuously starts a new conversion at every IDLE visit (every 18 cycles).

## Test plan
- Reset: assert `Resetn`=0 asynchronously between edges → `bcd`=0, `busy`=0, `done`=0 immediately; HEX0=1000000, HEX4..HEX1=1111111.
- Basic conversion: `load` 16'd255 at E0 → `busy`=1 after E0; `done`=1 only during E16–E17; `bcd`=20'h00255; HEX2/HEX1/HEX0 = 0100100/0010010/0010010; HEX4 and HEX3 blank.
- Boundaries:
  - `load` 16'hFFFF → `bcd`=20'h65535, HEX4=0000010.
  - `load` 16'd0 → `bcd`=0, `done` pulses once, only HEX0 lit.
- Ignored load: `load` 16'd300, then `load` 16'd1 at E5 and again at E16 → result is 20'h00300 and no second conversion starts. A later `load` 16'd1000 in IDLE → 20'h01000, with HEX2..HEX0 showing 0 (internal zeros not blanked).
- Reset mid-operation: `load` 16'd9999, pulse `Resetn` low after E8 → all outputs return to reset values. A subsequent `load` 16'd42 → 20'h00042 after exactly 16 cycles.
- BLANK_LEADING=0: `load` 16'd7 → HEX4..HEX1=1000000, HEX0=1111000.
